hazard_stall_controller: RTL and testbench

//  Sequences the 5-stage pipeline around hazards that forwarding cannot resolve.
//  - Load-use: inserts a one-cycle bubble.
//  - Taken branch in EX: flushes the wrong-path instructions.
//  - Data-memory wait: freezes the whole pipeline until dmem_ready.
//  - Memory timeout: enters a sticky error halt.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/hazard_stall_controller_sat_counter.sv | 46 ++++
 rtl/hazard_stall_controller.sv | 167 ++++++++++++++++
 tb/tb_hazard_stall_controller.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard stall controller.
//   hz_state_t : controller state encoding (RUN, MEM_WAIT, HALT)
//   REG_ZERO   : architectural x0, never a real producer
//   reg_match  : true when an ID source operand is live and names rd
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // A source operand only hazards if the ID instruction actually reads it.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] rs,
                                       input logic       use_rs);
        return use_rs && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear and load-one.
//   clk_i   : clock
//   rst_n_i : synchronous active-low reset, counter to zero
//   clr_i   : clear to zero (highest priority after reset)
//   load_i  : load the value one
//   inc_i   : increment, holding at all-ones
//   cnt_o   : current count
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, load-one, or saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = CNT_W'(1);
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard sequencer: load-use bubble, taken-branch flush,
// data-memory wait freeze and sticky memory-timeout halt.
//   CLK, RST_n            : clock, synchronous active-low reset
//   Rs1_ID/Rs2_ID         : ID source registers, qualified by UseRs1_ID/UseRs2_ID
//   Rd_EX, MemRead_EX     : EX destination and load flag
//   BranchTaken_EX        : branch/jump resolved taken in EX
//   DmemReq_MEM/DmemReady : MEM access request and completion
//   PCWrite, *_Write      : register enables (combinational)
//   *_Flush               : bubble inserts (combinational)
//   MemTimeout            : sticky error, set while halted
//   StallCycles           : saturating count of cycles with PCWrite low
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [4:0]       Rs1_ID,
    input  logic [4:0]       Rs2_ID,
    input  logic             UseRs1_ID,
    input  logic             UseRs2_ID,
    input  logic [4:0]       Rd_EX,
    input  logic             MemRead_EX,
    input  logic             BranchTaken_EX,
    input  logic             DmemReq_MEM,
    input  logic             DmemReady,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Write,
    output logic             ID_EX_Flush,
    output logic             EX_MEM_Write,
    output logic             MEM_WB_Flush,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCycles
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [CNT_W-1:0] timer_q;
    logic             timer_clr;
    logic             timer_load;
    logic             timer_inc;
    logic             lu_c;
    logic             memwait_c;
    logic             timer_at_limit;

    // Load-use: a load in EX feeds a live ID operand; x0 never hazards.
    assign lu_c = MemRead_EX && (Rd_EX != REG_ZERO) &&
                  (reg_match(Rd_EX, Rs1_ID, UseRs1_ID) ||
                   reg_match(Rd_EX, Rs2_ID, UseRs2_ID));

    assign memwait_c      = DmemReq_MEM && !DmemReady;
    assign timer_at_limit = (timer_q == TIMEOUT_CNT);

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and wait-timer control.
    always_comb begin
        state_d    = state_q;
        timer_clr  = 1'b0;
        timer_load = 1'b0;
        timer_inc  = 1'b0;
        case (state_q)
            RUN: begin
                if (memwait_c) begin
                    state_d    = MEM_WAIT;
                    timer_load = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Completion in the limit cycle still wins over the timeout.
                if (DmemReady) begin
                    state_d   = RUN;
                    timer_clr = 1'b1;
                end else if (timer_at_limit) begin
                    state_d = HALT;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d   = RUN;
                timer_clr = 1'b1;
            end
        endcase
    end

    // Output decode from current state and inputs.
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Write  = 1'b1;
        ID_EX_Flush  = 1'b0;
        EX_MEM_Write = 1'b1;
        MEM_WB_Flush = 1'b0;
        MemTimeout   = 1'b0;
        case (state_q)
            RUN, MEM_WAIT: begin
                // Freeze whenever the memory access is still outstanding; in
                // MEM_WAIT only DmemReady matters, EX contents are frozen.
                if ((state_q == RUN) ? memwait_c : !DmemReady) begin
                    PCWrite      = 1'b0;
                    IF_ID_Write  = 1'b0;
                    ID_EX_Write  = 1'b0;
                    EX_MEM_Write = 1'b0;
                    MEM_WB_Flush = 1'b1;
                end else if (BranchTaken_EX) begin
                    // ID holds a wrong-path instruction, so its lu is moot.
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                end else if (lu_c) begin
                    PCWrite     = 1'b0;
                    IF_ID_Write = 1'b0;
                    ID_EX_Flush = 1'b1;
                end
            end
            HALT: begin
                PCWrite      = 1'b0;
                IF_ID_Write  = 1'b0;
                ID_EX_Write  = 1'b0;
                EX_MEM_Write = 1'b0;
                MEM_WB_Flush = 1'b1;
                MemTimeout   = 1'b1;
            end
            default: begin
                PCWrite = 1'b1;
            end
        endcase
    end

    // Consecutive MEM_WAIT cycle timer.
    sat_counter #(.CNT_W(CNT_W)) u_wait_timer (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .clr_i   (timer_clr),
        .load_i  (timer_load),
        .inc_i   (timer_inc),
        .cnt_o   (timer_q)
    );

    // Stall statistics: every cycle the PC is held.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk_i   (CLK),
        .rst_n_i (RST_n),
        .clr_i   (1'b0),
        .load_i  (1'b0),
        .inc_i   (!PCWrite),
        .cnt_o   (StallCycles)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed scoreboard bench for hazard_stall_controller (TIMEOUT=4, CNT_W=3).
module tb_hazard_stall_controller;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 3;

    // Expected control vector order:
    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush, MemTimeout}
    localparam logic [7:0] DEF = 8'b1101_0100;
    localparam logic [7:0] LU  = 8'b0001_1100;
    localparam logic [7:0] BR  = 8'b1111_1100;
    localparam logic [7:0] FRZ = 8'b0000_0010;
    localparam logic [7:0] HLT = 8'b0000_0011;

    typedef struct {
        string            name;
        logic [7:0]       ctl;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic             CLK;
    logic             RST_n;
    logic [4:0]       Rs1_ID, Rs2_ID, Rd_EX;
    logic             UseRs1_ID, UseRs2_ID, MemRead_EX, BranchTaken_EX;
    logic             DmemReq_MEM, DmemReady;
    logic             PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write;
    logic             ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush, MemTimeout;
    logic [CNT_W-1:0] StallCycles;

    exp_t sb_q[$];
    int   n_tests;
    int   n_fail;

    hazard_stall_controller #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .CLK            (CLK),
        .RST_n          (RST_n),
        .Rs1_ID         (Rs1_ID),
        .Rs2_ID         (Rs2_ID),
        .UseRs1_ID      (UseRs1_ID),
        .UseRs2_ID      (UseRs2_ID),
        .Rd_EX          (Rd_EX),
        .MemRead_EX     (MemRead_EX),
        .BranchTaken_EX (BranchTaken_EX),
        .DmemReq_MEM    (DmemReq_MEM),
        .DmemReady      (DmemReady),
        .PCWrite        (PCWrite),
        .IF_ID_Write    (IF_ID_Write),
        .IF_ID_Flush    (IF_ID_Flush),
        .ID_EX_Write    (ID_EX_Write),
        .ID_EX_Flush    (ID_EX_Flush),
        .EX_MEM_Write   (EX_MEM_Write),
        .MEM_WB_Flush   (MEM_WB_Flush),
        .MemTimeout     (MemTimeout),
        .StallCycles    (StallCycles)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    always @(negedge CLK) begin
        if (sb_q.size() > 0) begin
            exp_t       e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write,
                   ID_EX_Flush, EX_MEM_Write, MEM_WB_Flush, MemTimeout};
            n_tests++;
            if (act !== e.ctl || StallCycles !== e.sc) begin
                n_fail++;
                $display("FAIL %s: ctl=%b stall=%0d, expected ctl=%b stall=%0d",
                         e.name, act, StallCycles, e.ctl, e.sc);
            end
        end
    end

    task automatic idle_inputs();
        Rs1_ID = 5'd0; Rs2_ID = 5'd0; Rd_EX = 5'd0;
        UseRs1_ID = 1'b0; UseRs2_ID = 1'b0; MemRead_EX = 1'b0;
        BranchTaken_EX = 1'b0; DmemReq_MEM = 1'b0; DmemReady = 1'b0;
    endtask

    task automatic do_reset();
        RST_n = 1'b0;
        idle_inputs();
        @(posedge CLK);
        #1;
        RST_n = 1'b1;
    endtask

    // One cycle of stimulus; expected response goes to the scoreboard.
    task automatic step(input string nm, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic br, input logic req, input logic rdy,
                        input logic [7:0] ctl, input int sc);
        exp_t e;
        MemRead_EX = mr; Rd_EX = rd;
        Rs1_ID = rs1; UseRs1_ID = u1;
        Rs2_ID = rs2; UseRs2_ID = u2;
        BranchTaken_EX = br; DmemReq_MEM = req; DmemReady = rdy;
        e.name = nm; e.ctl = ctl; e.sc = CNT_W'(sc);
        sb_q.push_back(e);
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input string nm, input logic [7:0] ctl, input int sc);
        step(nm, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, 0, ctl, sc);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        RST_n   = 1'b0;
        idle_inputs();
        @(posedge CLK);
        do_reset();

        idle("reset_defaults", DEF, 0);

        // Load-use on rs1: one bubble, then defaults.
        step("lu_rs1", 1, 5'd5, 5'd5, 1, 5'd0, 0, 0, 0, 0, LU, 0);
        idle("lu_after", DEF, 1);
        step("lu_rd_x0", 1, 5'd0, 5'd0, 1, 5'd0, 1, 0, 0, 0, DEF, 1);
        step("lu_rs1_unused", 1, 5'd5, 5'd5, 0, 5'd3, 1, 0, 0, 0, DEF, 1);
        step("lu_rs2", 1, 5'd7, 5'd1, 1, 5'd7, 1, 0, 0, 0, LU, 1);
        step("no_load_match", 0, 5'd7, 5'd7, 1, 5'd7, 1, 0, 0, 0, DEF, 2);

        // Taken branch beats a coincident load-use.
        step("branch_over_lu", 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 0, BR, 2);
        idle("branch_after", DEF, 2);

        // Three freeze cycles, then release re-evaluates the branch.
        step("mw_enter", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2);
        step("mw_ign_branch", 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 1, 0, FRZ, 3);
        step("mw_hold", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 4);
        step("mw_release_br", 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, 1, 1, BR, 5);
        idle("mw_after", DEF, 5);
        step("req_ready_now", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, DEF, 5);

        // Ready in the limit cycle releases without error.
        do_reset();
        step("lim_enter", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0);
        step("lim_t1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1);
        step("lim_t2", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2);
        step("lim_t3", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 3);
        step("lim_ready", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, DEF, 4);
        idle("lim_no_err", DEF, 4);

        // Timeout into sticky HALT; inputs ignored; counter saturates.
        do_reset();
        step("to_enter", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0);
        step("to_t1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1);
        step("to_t2", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2);
        step("to_t3", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 3);
        step("to_t4", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 4);
        step("halt_1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, HLT, 5);
        step("halt_ign_ready", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, HLT, 6);
        idle("halt_sticky", HLT, 7);
        step("halt_sat", 1, 5'd5, 5'd5, 1, 5'd0, 0, 1, 0, 0, HLT, 7);
        do_reset();
        idle("halt_reset", DEF, 0);

        // Reset mid-wait clears the timer: a full wait window is available again.
        step("mid_enter", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0);
        step("mid_t1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1);
        do_reset();
        idle("mid_reset", DEF, 0);
        step("mid2_enter", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 0);
        step("mid2_t1", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 1);
        step("mid2_t2", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 2);
        step("mid2_t3", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 0, FRZ, 3);
        step("mid2_ready", 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 1, 1, DEF, 4);

        @(negedge CLK);
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
